// File: rtl/proc_state_seq_if.sv
// Control bundle between the instruction-cycle sequencer and the datapath.
// The master side is the sequencer; the slave side is the datapath/memory.
interface proc_state_seq_if;
    logic        MEM_READY;
    logic        HALT_REQ;
    logic        OP_IS_LOAD;
    logic        OP_IS_STORE;
    logic        OP_WRITES_RF;
    logic [2:0]  STATE;
    logic        IR_LOAD;
    logic        PC_LOAD;
    logic        RF_WE;
    logic        MEM_RD;
    logic        MEM_WR;
    logic        HALTED;
    logic [31:0] RETIRE_CNT;

    modport master (
        input  MEM_READY, HALT_REQ, OP_IS_LOAD, OP_IS_STORE, OP_WRITES_RF,
        output STATE, IR_LOAD, PC_LOAD, RF_WE, MEM_RD, MEM_WR, HALTED, RETIRE_CNT
    );

    modport slave (
        output MEM_READY, HALT_REQ, OP_IS_LOAD, OP_IS_STORE, OP_WRITES_RF,
        input  STATE, IR_LOAD, PC_LOAD, RF_WE, MEM_RD, MEM_WR, HALTED, RETIRE_CNT
    );
endinterface

// File: rtl/proc_state_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXE/MEM/WB with memory
// wait states, halt, and a free-running retired-instruction counter.
module proc_state_seq #(
    parameter logic [31:0] RETIRE_INIT = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RESET,
    proc_state_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_INIT   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXE    = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_HALT   = 3'b110
    } state_e;

    state_e      r_state;
    logic [31:0] r_retire_cnt;
    logic        w_in_fetch;
    logic        w_in_mem;
    logic        w_in_wb;

    // NOTE: state and counter use non-blocking assignments so every flop
    // samples the pre-edge values; the async reset also zeroes all strobes
    // because they are pure decodes of r_state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state      <= S_INIT;
            r_retire_cnt <= RETIRE_INIT;
        end else begin
            // Every edge spent in WB leaves WB, so each one retires an instruction.
            if (r_state == S_WB)
                r_retire_cnt <= r_retire_cnt + 32'd1;

            case (r_state)
                S_INIT:   r_state <= S_FETCH;
                S_FETCH:  if (bus.MEM_READY) r_state <= S_DECODE;
                S_DECODE: r_state <= S_EXE;
                S_EXE:    r_state <= (bus.OP_IS_LOAD || bus.OP_IS_STORE) ? S_MEM : S_WB;
                S_MEM:    if (bus.MEM_READY) r_state <= S_WB;
                S_WB:     r_state <= bus.HALT_REQ ? S_HALT : S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_INIT;
            endcase
        end
    end

    assign w_in_fetch = (r_state == S_FETCH);
    assign w_in_mem   = (r_state == S_MEM);
    assign w_in_wb    = (r_state == S_WB);

    // Strobes are unregistered so they track wait states and reset in the same cycle.
    assign bus.STATE      = r_state;
    assign bus.MEM_RD     = w_in_fetch || (w_in_mem && bus.OP_IS_LOAD);
    assign bus.MEM_WR     = w_in_mem && bus.OP_IS_STORE && !bus.OP_IS_LOAD;
    assign bus.IR_LOAD    = w_in_fetch && bus.MEM_READY;
    assign bus.PC_LOAD    = w_in_wb;
    assign bus.RF_WE      = w_in_wb && bus.OP_WRITES_RF;
    assign bus.HALTED     = (r_state == S_HALT);
    assign bus.RETIRE_CNT = r_retire_cnt;

endmodule

// File: tb/tb_proc_state_seq.sv
// Scoreboard bench for proc_state_seq: two instances (RETIRE_INIT 0 and
// FFFFFFFF) share stimulus; a monitor pops expected per-cycle responses.
module tb_proc_state_seq;

    logic clk;
    logic rst_n;
    logic mr, hr, ld, sv, wrf;

    proc_state_seq_if if0 ();
    proc_state_seq_if if1 ();

    assign if0.MEM_READY    = mr;
    assign if0.HALT_REQ     = hr;
    assign if0.OP_IS_LOAD   = ld;
    assign if0.OP_IS_STORE  = sv;
    assign if0.OP_WRITES_RF = wrf;
    assign if1.MEM_READY    = mr;
    assign if1.HALT_REQ     = hr;
    assign if1.OP_IS_LOAD   = ld;
    assign if1.OP_IS_STORE  = sv;
    assign if1.OP_WRITES_RF = wrf;

    proc_state_seq #(.RETIRE_INIT(32'h0000_0000)) dut0 (.CLK(clk), .RESET(rst_n), .bus(if0.master));
    proc_state_seq #(.RETIRE_INIT(32'hFFFF_FFFF)) dut1 (.CLK(clk), .RESET(rst_n), .bus(if1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic        mr, hr, ld, sv, wrf;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    event mon_ev;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected strobes {IR_LOAD, PC_LOAD, RF_WE, MEM_RD, MEM_WR, HALTED}
    function automatic logic [5:0] strobes(input exp_t e);
        logic ir, pc, rf, rd, wr, hl;
        ir = (e.st == 3'd1) && e.mr;
        pc = (e.st == 3'd5);
        rf = (e.st == 3'd5) && e.wrf;
        rd = (e.st == 3'd1) || ((e.st == 3'd4) && e.ld);
        wr = (e.st == 3'd4) && e.sv && !e.ld;
        hl = (e.st == 3'd6);
        return {ir, pc, rf, rd, wr, hl};
    endfunction

    // Monitor: compare on every falling edge, or on demand for async events.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or mon_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, " state0"}, {29'd0, if0.STATE}, {29'd0, e.st});
                check({e.tag, " state1"}, {29'd0, if1.STATE}, {29'd0, e.st});
                check({e.tag, " strobes"},
                      {26'd0, if0.IR_LOAD, if0.PC_LOAD, if0.RF_WE, if0.MEM_RD, if0.MEM_WR, if0.HALTED},
                      {26'd0, strobes(e)});
                check({e.tag, " cnt0"}, if0.RETIRE_CNT, e.cnt);
                check({e.tag, " cnt1"}, if1.RETIRE_CNT, e.cnt - 32'd1);
            end
        end
    end

    // One cycle: drive inputs just after the edge and queue the expected response.
    task automatic cyc(input string tag, input logic [2:0] st,
                       input logic i_mr, input logic i_hr, input logic i_ld,
                       input logic i_sv, input logic i_wrf, input logic [31:0] c);
        exp_t e;
        @(posedge clk);
        #1;
        mr = i_mr; hr = i_hr; ld = i_ld; sv = i_sv; wrf = i_wrf;
        e.tag = tag; e.st = st; e.mr = i_mr; e.hr = i_hr;
        e.ld = i_ld; e.sv = i_sv; e.wrf = i_wrf; e.cnt = c;
        q.push_back(e);
    endtask

    task automatic rst_cyc(input string tag, input logic level);
        @(posedge clk);
        #1;
        rst_n = level;
        cyc_push(tag);
    endtask

    task automatic cyc_push(input string tag);
        exp_t e;
        e.tag = tag; e.st = 3'd0; e.mr = mr; e.hr = hr;
        e.ld = ld; e.sv = sv; e.wrf = wrf; e.cnt = 32'd0;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        mr = 1'b1; hr = 1'b0; ld = 1'b0; sv = 1'b0; wrf = 1'b0;

        // Reset, then first fetch with memory ready.
        rst_cyc("rst_a", 1'b0);
        rst_cyc("rst_b", 1'b0);
        rst_cyc("init", 1'b1);

        // ALU instruction: 4 cycles, retire 0 -> 1 (dut1 wraps FFFFFFFF -> 0).
        cyc("alu_f",   3'd1, 1, 0, 0, 0, 1, 32'd0);
        cyc("alu_d",   3'd2, 0, 0, 0, 0, 1, 32'd0);
        cyc("alu_e",   3'd3, 1, 0, 0, 0, 1, 32'd0);
        cyc("alu_wb",  3'd5, 1, 0, 0, 0, 1, 32'd0);

        // Load with two wait cycles in MEM: 7 cycles total.
        cyc("ld_f",    3'd1, 1, 0, 1, 0, 1, 32'd1);
        cyc("ld_d",    3'd2, 1, 0, 1, 0, 1, 32'd1);
        cyc("ld_e",    3'd3, 1, 0, 1, 0, 1, 32'd1);
        cyc("ld_m0",   3'd4, 0, 0, 1, 0, 1, 32'd1);
        cyc("ld_m1",   3'd4, 0, 0, 1, 0, 1, 32'd1);
        cyc("ld_m2",   3'd4, 1, 0, 1, 0, 1, 32'd1);
        cyc("ld_wb",   3'd5, 1, 0, 1, 0, 1, 32'd1);

        // Store with one FETCH wait; no RF write.
        cyc("st_fw",   3'd1, 0, 0, 0, 1, 0, 32'd2);
        cyc("st_f",    3'd1, 1, 0, 0, 1, 0, 32'd2);
        cyc("st_d",    3'd2, 1, 0, 0, 1, 0, 32'd2);
        cyc("st_e",    3'd3, 1, 0, 0, 1, 0, 32'd2);
        cyc("st_m",    3'd4, 1, 0, 0, 1, 0, 32'd2);
        cyc("st_wb",   3'd5, 1, 0, 0, 1, 0, 32'd2);

        // Load+store treated as load; MEM_READY and HALT_REQ ignored outside FETCH/MEM/WB.
        cyc("ls_f",    3'd1, 1, 0, 1, 1, 1, 32'd3);
        cyc("ls_d",    3'd2, 0, 1, 1, 1, 1, 32'd3);
        cyc("ls_e",    3'd3, 0, 1, 1, 1, 1, 32'd3);
        cyc("ls_m",    3'd4, 1, 0, 1, 1, 1, 32'd3);
        cyc("ls_wb",   3'd5, 1, 0, 1, 1, 1, 32'd3);

        // Store stalled in MEM, aborted by an asynchronous reset.
        cyc("ab_f",    3'd1, 1, 0, 0, 1, 0, 32'd4);
        cyc("ab_d",    3'd2, 1, 0, 0, 1, 0, 32'd4);
        cyc("ab_e",    3'd3, 1, 0, 0, 1, 0, 32'd4);
        cyc("ab_m",    3'd4, 0, 0, 0, 1, 0, 32'd4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cyc_push("ab_rst");
        ->mon_ev;
        rst_cyc("ab_hold", 1'b0);
        rst_cyc("ab_init", 1'b1);

        // Halt: DECODE pulse ignored, WB request taken, dut1 count wraps to 0.
        cyc("h_f",     3'd1, 1, 0, 0, 0, 1, 32'd0);
        cyc("h_d",     3'd2, 1, 1, 0, 0, 1, 32'd0);
        cyc("h_e",     3'd3, 1, 0, 0, 0, 1, 32'd0);
        cyc("h_wb",    3'd5, 1, 1, 0, 0, 1, 32'd0);
        for (int i = 0; i < 10; i++)
            cyc($sformatf("halt%0d", i), 3'd6, i[0], 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);

        repeat (3) @(negedge clk);
        check("drain", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
